rob_dispatch: RTL

Dispatch stage that sits between decode/rename and the reorder buffer and drives its 4-wide insertion port. It buffers renamed instructions in an 8-entry FIFO and packs them into groups of up to 4 with lanes filled contiguously from lane 0. It holds a mirror of the ROB occupancy so that insertions never overrun the ROB. It also mirrors the ROB tail so that every dispatched instruction is tagged with its ROB index for the execute units.

---
 rtl/rob_dispatch.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/rob_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : rob_dispatch
// Purpose  : Buffers renamed instructions and packs them into contiguous
//            4-wide ROB insertion groups, tracking ROB tail and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module rob_dispatch #(
    parameter int QDEPTH    = 8,
    parameter int ROB_LIMIT = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  decValid,
    input  logic [4:0]  decArchReg0,
    input  logic [4:0]  decArchReg1,
    input  logic [4:0]  decArchReg2,
    input  logic [4:0]  decArchReg3,
    input  logic [7:0]  decPhysReg0,
    input  logic [7:0]  decPhysReg1,
    input  logic [7:0]  decPhysReg2,
    input  logic [7:0]  decPhysReg3,
    input  logic [10:0] decOpcode0,
    input  logic [10:0] decOpcode1,
    input  logic [10:0] decOpcode2,
    input  logic [10:0] decOpcode3,
    output logic        decReady,
    input  logic        flush,
    input  logic [2:0]  numCommited,
    input  logic        robFull,
    output logic [3:0]  inserted,
    output logic [4:0]  archReg0,
    output logic [4:0]  archReg1,
    output logic [4:0]  archReg2,
    output logic [4:0]  archReg3,
    output logic [7:0]  physReg0,
    output logic [7:0]  physReg1,
    output logic [7:0]  physReg2,
    output logic [7:0]  physReg3,
    output logic [10:0] opcode0,
    output logic [10:0] opcode1,
    output logic [10:0] opcode2,
    output logic [10:0] opcode3,
    output logic [5:0]  robIndex0,
    output logic [5:0]  robIndex1,
    output logic [5:0]  robIndex2,
    output logic [5:0]  robIndex3,
    output logic [6:0]  occupancy,
    output logic        protoErr
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 24;
    localparam logic [CW-1:0] c_READY_MAX = CW'(QDEPTH - 4);
    localparam logic [CW-1:0] c_FOUR      = CW'(4);
    localparam logic [6:0]    c_ROB_LIMIT = 7'(ROB_LIMIT);

    // Entry layout: {arch[23:19], phys[18:11], opcode[10:0]}
    logic [EW-1:0] w_dec_entry [4];
    logic [EW-1:0] r_mem [QDEPTH];
    logic [EW-1:0] w_pop_entry [4];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [1:0]    w_slot [4];
    logic [2:0]    w_push_cnt;
    logic [2:0]    w_push_amt;
    logic          w_push;
    logic [2:0]    w_avail;
    logic [2:0]    w_credit;
    logic [2:0]    w_k;
    logic [3:0]    w_mask;
    logic [2:0]    w_ins_cnt;
    logic [6:0]    w_occ_next0;
    logic [6:0]    w_room;

    logic [3:0]    r_ins;
    logic [4:0]    r_arch [4];
    logic [7:0]    r_phys [4];
    logic [10:0]   r_op [4];
    logic [5:0]    r_tail;
    logic [6:0]    r_occ;
    logic          r_perr;

    assign w_dec_entry[0] = {decArchReg0, decPhysReg0, decOpcode0};
    assign w_dec_entry[1] = {decArchReg1, decPhysReg1, decOpcode1};
    assign w_dec_entry[2] = {decArchReg2, decPhysReg2, decOpcode2};
    assign w_dec_entry[3] = {decArchReg3, decPhysReg3, decOpcode3};

    assign decReady   = (r_count <= c_READY_MAX);
    assign w_push     = decReady & (|decValid) & ~flush & ~reset;
    assign w_push_amt = w_push ? w_push_cnt : 3'd0;
    assign w_ins_cnt  = {2'b00, r_ins[0]} + {2'b00, r_ins[1]}
                      + {2'b00, r_ins[2]} + {2'b00, r_ins[3]};

    // Each valid lane lands at an offset equal to the valid lanes below it
    always_comb begin
        w_push_cnt = 3'd0;
        for (int j = 0; j < 4; j++) begin
            w_slot[j]  = w_push_cnt[1:0];
            w_push_cnt = w_push_cnt + {2'b00, decValid[j]};
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_pop_entry[i] = r_mem[r_rd_ptr + PW'(i)];
        end
    end

    always_comb begin
        w_occ_next0 = r_occ - {4'b0000, numCommited};
        w_room      = 7'd0;
        if (w_occ_next0 < c_ROB_LIMIT) begin
            w_room = c_ROB_LIMIT - w_occ_next0;
        end
        w_credit = (w_room >= 7'd4) ? 3'd4 : w_room[2:0];
        w_avail  = (r_count >= c_FOUR) ? 3'd4 : r_count[2:0];
        w_k      = (w_avail < w_credit) ? w_avail : w_credit;
        if (flush || reset) begin
            w_k = 3'd0;
        end
        case (w_k)
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            3'd3:    w_mask = 4'b0111;
            3'd4:    w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int j = 0; j < 4; j++) begin
                if (decValid[j]) begin
                    r_mem[r_wr_ptr + PW'(w_slot[j])] <= w_dec_entry[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ins    <= '0;
            r_tail   <= '0;
            r_occ    <= '0;
            r_perr   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_arch[i] <= '0;
                r_phys[i] <= '0;
                r_op[i]   <= '0;
            end
        end else begin
            // The ROB consumes whatever is presented, even in a flush cycle
            r_tail <= r_tail + {3'b000, w_ins_cnt};
            r_occ  <= w_occ_next0 + {4'b0000, w_k};
            r_ins  <= w_mask;
            if (robFull && (|r_ins)) begin
                r_perr <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (w_mask[i]) begin
                    {r_arch[i], r_phys[i], r_op[i]} <= w_pop_entry[i];
                end else begin
                    r_arch[i] <= '0;
                    r_phys[i] <= '0;
                    r_op[i]   <= '0;
                end
            end
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + PW'(w_push_amt);
                r_rd_ptr <= r_rd_ptr + PW'(w_k);
                r_count  <= r_count + CW'(w_push_amt) - CW'(w_k);
            end
        end
    end

    assign inserted  = r_ins;
    assign archReg0  = r_arch[0];
    assign archReg1  = r_arch[1];
    assign archReg2  = r_arch[2];
    assign archReg3  = r_arch[3];
    assign physReg0  = r_phys[0];
    assign physReg1  = r_phys[1];
    assign physReg2  = r_phys[2];
    assign physReg3  = r_phys[3];
    assign opcode0   = r_op[0];
    assign opcode1   = r_op[1];
    assign opcode2   = r_op[2];
    assign opcode3   = r_op[3];
    assign robIndex0 = r_tail;
    assign robIndex1 = r_tail + 6'd1;
    assign robIndex2 = r_tail + 6'd2;
    assign robIndex3 = r_tail + 6'd3;
    assign occupancy = r_occ;
    assign protoErr  = r_perr;

endmodule
`default_nettype wire
